// File: rtl/enigma_pkg.sv
// Shared definitions for the rotor cipher core: FSM encoding, default
// geometry and the rotor-index width helper.
package enigma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  localparam int DEF_SYM_W = 6;
  localparam int DEF_N_ROT = 3;

  function automatic int ri_width(input int n_rot);
    if (n_rot > 1) begin
      return $clog2(n_rot);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/enigma_rotor.sv
// One rotor: forward table, inverse table, stepping offset and the two
// offset-adjusted lookups. Tables are deliberately not reset.
module enigma_rotor import enigma_pkg::*; #(
  parameter int SYM_W = DEF_SYM_W
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             wr_en,
  input  logic [SYM_W-1:0] wr_entry,
  input  logic [SYM_W-1:0] wr_data,
  input  logic             off_clr,
  input  logic             step,
  input  logic [SYM_W-1:0] fwd_in,
  output logic [SYM_W-1:0] fwd_out,
  input  logic [SYM_W-1:0] rev_in,
  output logic [SYM_W-1:0] rev_out,
  output logic             wrap
);

  localparam int A = 1 << SYM_W;

  logic [SYM_W-1:0] t_r    [A];
  logic [SYM_W-1:0] tinv_r [A];
  logic [SYM_W-1:0] off_r;
  logic [SYM_W-1:0] fwd_idx_s;

  // table write port; the inverse is built alongside so decrypt needs no search
  always_ff @(posedge clk) begin
    if (wr_en) begin
      t_r[wr_entry]   <= wr_data;
      tinv_r[wr_data] <= wr_entry;
    end
  end

  // rotor position register
  always_ff @(posedge clk) begin
    if (srst) begin
      off_r <= {SYM_W{1'b0}};
    end else if (off_clr) begin
      off_r <= {SYM_W{1'b0}};
    end else if (step) begin
      off_r <= off_r + {{(SYM_W-1){1'b0}}, 1'b1};
    end
  end

  // modulo-A arithmetic falls out of the SYM_W-bit truncation
  assign fwd_idx_s = fwd_in + off_r;
  assign fwd_out   = t_r[fwd_idx_s];
  assign rev_out   = tinv_r[rev_in] - off_r;
  assign wrap      = (off_r == {SYM_W{1'b1}});

endmodule

// File: rtl/enigma_rotor_core.sv
// Rotor cipher core: table load FSM, N_ROT chained rotors with odometer
// stepping, and a one-entry registered output with valid/ready handshake.
module enigma_rotor_core import enigma_pkg::*; #(
  parameter  int SYM_W = DEF_SYM_W,
  parameter  int N_ROT = DEF_N_ROT,
  localparam int RI_W  = ri_width(N_ROT)
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  load,
  input  logic [RI_W+SYM_W-1:0] load_idx,
  input  logic                  crypt_mode,
  input  logic [SYM_W-1:0]      code_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [SYM_W-1:0]      code_out,
  output logic                  code_valid,
  input  logic                  out_ready
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [SYM_W-1:0] code_out_r;
  logic             code_valid_r;
  logic             enter_load_s;
  logic             wr_active_s;
  logic             in_ready_s;
  logic             accept_s;
  logic [RI_W-1:0]  rot_sel_s;
  logic [SYM_W-1:0] entry_s;
  logic [SYM_W-1:0] result_s;
  logic [N_ROT-1:0] wrap_s;
  logic [N_ROT-1:0] step_s;

  // FSM state register
  always_ff @(posedge clk) begin
    if (srst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  if (load) state_nxt_s = ST_LOAD;  else state_nxt_s = ST_IDLE;
      ST_LOAD:  if (load) state_nxt_s = ST_LOAD;  else state_nxt_s = ST_READY;
      ST_READY: if (load) state_nxt_s = ST_LOAD;  else state_nxt_s = ST_READY;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  assign enter_load_s = load && (state_r != ST_LOAD);
  assign wr_active_s  = load && (state_r == ST_LOAD);
  assign in_ready_s   = (state_r == ST_READY) && !load && (!code_valid_r || out_ready);
  assign accept_s     = in_valid && in_ready_s;
  assign rot_sel_s    = load_idx[RI_W+SYM_W-1:SYM_W];
  assign entry_s      = load_idx[SYM_W-1:0];

  // odometer: rotor k steps when every lower rotor is at A-1 on this accept
  always_comb begin
    logic carry_v;
    carry_v = accept_s;
    step_s  = {N_ROT{1'b0}};
    for (int k = 0; k < N_ROT; k++) begin
      step_s[k] = carry_v;
      carry_v   = carry_v & wrap_s[k];
    end
  end

  for (genvar k = 0; k < N_ROT; k++) begin : g_rot
    logic [SYM_W-1:0] f_in_s;
    logic [SYM_W-1:0] f_out_s;
    logic [SYM_W-1:0] r_in_s;
    logic [SYM_W-1:0] r_out_s;
    logic             wr_en_s;

    if (k == 0) begin : g_head
      assign f_in_s = code_in;
    end else begin : g_link
      assign f_in_s = g_rot[k-1].f_out_s;
    end

    if (k == N_ROT - 1) begin : g_tail
      assign r_in_s = code_in;
    end else begin : g_back
      assign r_in_s = g_rot[k+1].r_out_s;
    end

    // rotor indices at or above N_ROT never match, so those writes drop out
    assign wr_en_s = wr_active_s && (rot_sel_s == RI_W'(k));

    enigma_rotor #(.SYM_W(SYM_W)) u_rot (
      .clk      (clk),
      .srst     (srst),
      .wr_en    (wr_en_s),
      .wr_entry (entry_s),
      .wr_data  (code_in),
      .off_clr  (enter_load_s),
      .step     (step_s[k]),
      .fwd_in   (f_in_s),
      .fwd_out  (f_out_s),
      .rev_in   (r_in_s),
      .rev_out  (r_out_s),
      .wrap     (wrap_s[k])
    );
  end

  assign result_s = crypt_mode ? g_rot[0].r_out_s : g_rot[N_ROT-1].f_out_s;

  // output register; a same-cycle accept wins over a drain
  always_ff @(posedge clk) begin
    if (srst) begin
      code_out_r   <= {SYM_W{1'b0}};
      code_valid_r <= 1'b0;
    end else if (enter_load_s) begin
      code_valid_r <= 1'b0;
    end else if (accept_s) begin
      code_out_r   <= result_s;
      code_valid_r <= 1'b1;
    end else if (out_ready) begin
      code_valid_r <= 1'b0;
    end
  end

  assign in_ready   = in_ready_s;
  assign code_out   = code_out_r;
  assign code_valid = code_valid_r;

endmodule

// File: tb/tb_enigma_rotor_core.sv
// Scoreboard bench for enigma_rotor_core: stimulus pushes expected symbols,
// a negedge monitor pops them whenever an output transfer happens.
module tb_enigma_rotor_core;

  logic       clk = 1'b0;
  logic       srst;
  logic       load;
  logic [7:0] load_idx;
  logic       crypt_mode;
  logic [5:0] code_in;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] code_out;
  logic       code_valid;
  logic       out_ready;

  int         checks = 0;
  int         errors = 0;
  int         exp_q[$];
  int         moff[3];
  int         cur_kind;
  int         last_exp;
  int         ct[112];
  int         mon_exp;
  int         stall_exp;
  time        t0;
  time        t1;

  always #5 clk = ~clk;

  enigma_rotor_core #(.SYM_W(6), .N_ROT(3)) dut (
    .clk        (clk),
    .srst       (srst),
    .load       (load),
    .load_idx   (load_idx),
    .crypt_mode (crypt_mode),
    .code_in    (code_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .code_out   (code_out),
    .code_valid (code_valid),
    .out_ready  (out_ready)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // rotorA/B/C are affine permutations a*e+b mod 64 with odd a
  function automatic int aff_a(input int r);
    case (r)
      0:       return 5;
      1:       return 13;
      default: return 37;
    endcase
  endfunction
  function automatic int aff_b(input int r);
    case (r)
      0:       return 17;
      1:       return 3;
      default: return 41;
    endcase
  endfunction
  function automatic int aff_ai(input int r);
    case (r)
      0:       return 13;
      1:       return 5;
      default: return 45;
    endcase
  endfunction

  function automatic int tf(input int kind, input int r, input int e);
    if (kind == 0) return e & 63;
    return (aff_a(r) * e + aff_b(r)) & 63;
  endfunction
  function automatic int tinvf(input int kind, input int r, input int y);
    if (kind == 0) return y & 63;
    return (aff_ai(r) * (y - aff_b(r))) & 63;
  endfunction

  function automatic int model(input int kind, input int x, input bit mode);
    int v;
    v = x & 63;
    if (!mode) begin
      for (int k = 0; k < 3; k++) v = tf(kind, k, (v + moff[k]) & 63);
    end else begin
      for (int k = 2; k >= 0; k--) v = (tinvf(kind, k, v) - moff[k]) & 63;
    end
    return v;
  endfunction

  task automatic mstep();
    bit carry;
    carry = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (carry) begin
        moff[k] = (moff[k] + 1) & 63;
        carry   = (moff[k] == 0);
      end
    end
  endtask

  // issue one symbol; exp_val < 0 means take the expectation from the model
  task automatic send(input int sym, input bit mode, input int exp_val = -1);
    bit done;
    done       = 1'b0;
    code_in    = 6'(sym);
    crypt_mode = mode;
    in_valid   = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (exp_val < 0) last_exp = model(cur_kind, sym, mode);
        else             last_exp = exp_val;
        exp_q.push_back(last_exp);
        mstep();
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=no_accept required=accept sym=%0d", sym);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic load_tables(input int kind);
    drain();
    in_valid = 1'b0;
    load     = 1'b1;
    load_idx = 8'd0;
    code_in  = 6'd0;
    @(posedge clk); #1;
    for (int r = 0; r < 3; r++) begin
      for (int e = 0; e < 64; e++) begin
        load_idx = 8'(r * 64 + e);
        code_in  = 6'(tf(kind, r, e));
        @(posedge clk); #1;
      end
    end
    load_idx = 8'(3 * 64 + 5);
    code_in  = 6'd0;
    @(posedge clk); #1;
    load = 1'b0;
    @(posedge clk); #1;
    cur_kind = kind;
    moff     = '{0, 0, 0};
  endtask

  // scoreboard monitor: an output transfers on the edge after this sample
  always @(negedge clk) begin
    if (code_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%0d required=none", code_out);
      end else begin
        mon_exp = exp_q.pop_front();
        check("code_out", int'(code_out), mon_exp);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    srst = 1'b1; load = 1'b0; load_idx = 8'd0; crypt_mode = 1'b0;
    code_in = 6'd0; in_valid = 1'b0; out_ready = 1'b1;
    cur_kind = 0; moff = '{0, 0, 0};
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_code_valid", int'(code_valid), 0);
    check("rst_code_out", int'(code_out), 0);
    check("rst_state", int'(dut.state_r), 0);
    @(posedge clk); #1;
    srst = 1'b0;

    // identity tables, 5,5,5 -> 5,6,7
    load_tables(0);
    send(5, 1'b0, 5);
    send(5, 1'b0, 6);
    send(5, 1'b0, 7);
    in_valid = 1'b0;
    drain();

    // 64 accepts carry into rotor 1, then input 0 -> 1
    load_tables(0);
    for (int i = 0; i < 64; i++) send((3 * i) & 63, 1'b0, (4 * i) & 63);
    in_valid = 1'b0;
    drain();
    check("odo_off0", int'(dut.g_rot[0].u_rot.off_r), 0);
    check("odo_off1", int'(dut.g_rot[1].u_rot.off_r), 1);
    check("odo_off2", int'(dut.g_rot[2].u_rot.off_r), 0);
    send(0, 1'b0, 1);
    in_valid = 1'b0;

    // decrypt the same sequence after a reload
    load_tables(0);
    for (int i = 0; i < 64; i++) send((4 * i) & 63, 1'b1, (3 * i) & 63);
    send(1, 1'b1, 0);
    in_valid = 1'b0;

    // rotorA/B/C round trip over 112 symbols
    load_tables(1);
    for (int i = 0; i < 112; i++) begin
      send((i * 7 + 11) & 63, 1'b0);
      ct[i] = last_exp;
    end
    in_valid = 1'b0;
    load_tables(1);
    for (int i = 0; i < 112; i++) send(ct[i], 1'b1, (i * 7 + 11) & 63);
    in_valid = 1'b0;
    drain();

    // backpressure: three stalled cycles, then a stall-free stream
    out_ready = 1'b0;
    send(9, 1'b0);
    stall_exp = last_exp;
    code_in   = 6'd10;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_code_valid", int'(code_valid), 1);
      check("stall_code_out", int'(code_out), stall_exp);
      check("stall_off0", int'(dut.g_rot[0].u_rot.off_r), moff[0]);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    t0 = $time;
    send(10, 1'b0);
    send(11, 1'b0);
    send(12, 1'b0);
    t1 = $time;
    in_valid = 1'b0;
    check("resume_cycles", int'((t1 - t0) / 10), 3);
    drain();

    // load together with a valid symbol: no accept, offsets cleared
    send(20, 1'b0);
    send(21, 1'b0);
    code_in = 6'd22;
    load    = 1'b1;
    @(negedge clk);
    check("load_prio_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    check("load_prio_state", int'(dut.state_r), 1);
    check("load_prio_off0", int'(dut.g_rot[0].u_rot.off_r), 0);
    check("load_prio_off1", int'(dut.g_rot[1].u_rot.off_r), 0);
    check("load_prio_off2", int'(dut.g_rot[2].u_rot.off_r), 0);
    load     = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("load_prio_ready", int'(dut.state_r), 2);
    moff = '{0, 0, 0};
    send(22, 1'b0);
    in_valid = 1'b0;
    drain();

    // srst mid-stream discards the pending output, tables survive
    out_ready = 1'b0;
    send(30, 1'b0);
    in_valid = 1'b0;
    srst     = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("srst_code_valid", int'(code_valid), 0);
    check("srst_code_out", int'(code_out), 0);
    check("srst_state", int'(dut.state_r), 0);
    check("srst_in_ready", int'(in_ready), 0);
    check("srst_off0", int'(dut.g_rot[0].u_rot.off_r), 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    @(posedge clk); #1;
    moff = '{0, 0, 0};
    send(30, 1'b0);
    in_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
